dut2vip_axis_tx: RTL and testbench
==================================

# dut2vip_axis_tx

C2H-direction transmitter for the VIP link: captures one wide DUT result vector in a single cycle and serializes it into a framed AXI4-Stream packet for the XDMA C2H channel. One header beat, then WORDS_NUM data beats, with tlast on the final beat. It sits between the DUT output bus and the XDMA `s_axis_c2h` port. It is the transmitting counterpart of the H2C receive path, which deserializes stream words into the vip2dut bus.

## Interface
- `C_DATA_WIDTH`, 256: AXI-Stream data width in bits; must be a multiple of 64.
- `WORDS_NUM`, 16: data beats per frame; range 1..65535.
- `m_axis_aclk`, in, 1: the single clock; all logic is synchronous to its rising edge.
- `m_axis_areset`, in, 1: reset, synchronous, active-high.
- `cap_valid`, in, 1: the vector on `cap_bus` is offered for transmission.
- `cap_ready`, out, 1: the block can accept a vector; a capture occurs on `cap_valid & cap_ready`.
- `cap_bus`, in, C_DATA_WIDTH*WORDS_NUM: the DUT result vector.
- `m_axis_tvalid`, out, 1: standard AXI-Stream master valid.
- `m_axis_tready`, in, 1: standard AXI-Stream master ready.
- `m_axis_tdata`, out, C_DATA_WIDTH: standard AXI-Stream master data.
- `m_axis_tkeep`, out, C_DATA_WIDTH/8: standard AXI-Stream master byte enables.
- `m_axis_tlast`, out, 1: standard AXI-Stream master end-of-packet.
- `busy`, out, 1: a frame is in flight (any state other than IDLE).
- `frame_seq`, out, 16: sequence number of the next frame to be sent.

## Operation
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - `cap_ready`=1, `m_axis_tvalid`=0.
  - On capture, latch all of `cap_bus` into a snapshot register, clear the beat counter, and go to HDR.
- HDR: drive the header beat.
  - `tdata[15:0]` = 16'hA5C3 (magic).
  - `tdata[31:16]` = `frame_seq`.
  - `tdata[47:32]` = WORDS_NUM.
  - All other bits 0.
  - `tlast` = 0.
  - On handshake, go to DATA.
- DATA:
  - Beat i (0..WORDS_NUM-1) drives `tdata` = snapshot[i*C_DATA_WIDTH +: C_DATA_WIDTH]; the least significant word is sent first.
  - `tlast` = 1 only when i == WORDS_NUM-1.
  - On handshake of a non-last beat, increment i.
  - On handshake of the last beat, increment `frame_seq` (16-bit wrap, 16'hFFFF -> 16'h0000) and go to IDLE.
- `m_axis_tkeep` is all ones whenever `m_axis_tvalid`=1; it is 0 otherwise.
- `cap_ready` is 0 in HDR and DATA. `cap_valid` in those states is ignored: no capture, and the snapshot is unchanged.
- The snapshot is written only on capture; changes on `cap_bus` after capture do not affect the frame in flight.
- Reset mid-frame:
  - The next edge forces IDLE, `tvalid`=0, `tlast`=0, `frame_seq`=0.
  - The partial frame is abandoned, with no tlast emitted.
  - The downstream consumer must discard it.
- Reset values: `cap_ready`=1, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0, `busy`=0, `frame_seq`=0.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from `m_axis_tready` or `cap_valid` to any output.
- Capture at edge N: header `tvalid`=1 from cycle N+1.
- With `tready` held at 1, one beat is transferred per cycle:
  - A frame occupies WORDS_NUM+1 cycles.
  - `cap_ready` returns high in the cycle after the last-beat handshake.
  - Throughput is one frame per WORDS_NUM+2 cycles.
- AXI rules:
  - Once asserted, `tvalid` stays high until handshake.
  - `tdata`, `tkeep` and `tlast` are stable while `tvalid & ~tready`.
  - `tvalid` does not depend on `tready`.
- Back-to-back: a `cap_valid` held high through a frame is accepted in the first IDLE cycle after the frame ends.
- Reset has priority over a simultaneous capture or handshake in the same cycle.

## Test plan
- Single frame:
  - Stimulus: C_DATA_WIDTH=256, WORDS_NUM=16; `cap_bus` word i = {8{32'h1000_0000+i}}; `tready`=1.
  - Required response: 17 beats on consecutive cycles. Header = 16'hA5C3, seq 0, count 16. Data words 0..15 in order; `tlast` only on beat 17. Then `frame_seq`=1 and `cap_ready`=1.
- Backpressure:
  - Stimulus: toggle `tready` pseudo-randomly at 50%.
  - Required response: `tdata`/`tlast` stable during every stall. Beat order and content identical to the single-frame case. No beat is duplicated or lost.
- Capture isolation:
  - Stimulus: change `cap_bus` and pulse `cap_valid` during DATA.
  - Required response: the frame carries only the originally captured data. `cap_ready`=0 throughout. No second frame is started.
- Sequence wrap:
  - Stimulus: send 65537 frames (or preload the counter in the bench via force).
  - Required response: header seq runs 16'hFFFE, 16'hFFFF, 16'h0000.
- Reset mid-frame:
  - Stimulus: assert `m_axis_areset` for 1 cycle after data beat 5 handshakes.
  - Required response: next cycle `tvalid`=0, `busy`=0, `frame_seq`=0. The following capture produces a full frame with seq 0.
- WORDS_NUM=1:
  - Stimulus: a single capture.
  - Required response: header beat (count 1) followed by one data beat with `tlast`=1; 2 beats total.

Source files
------------

// File: rtl/dut2vip_axis_tx_if.sv
// Bundle for the C2H transmit path: DUT capture handshake, AXI-Stream master
// toward the XDMA s_axis_c2h port, and frame status.
interface dut2vip_axis_tx_if #(
  parameter int C_DATA_WIDTH = 256,
  parameter int WORDS_NUM    = 16
);
  logic                                cap_valid;
  logic                                cap_ready;
  logic [C_DATA_WIDTH*WORDS_NUM-1:0]   cap_bus;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;
  logic [C_DATA_WIDTH-1:0]             m_axis_tdata;
  logic [C_DATA_WIDTH/8-1:0]           m_axis_tkeep;
  logic                                m_axis_tlast;
  logic                                busy;
  logic [15:0]                         frame_seq;

  // Transmitter side
  modport master (
    input  cap_valid, cap_bus, m_axis_tready,
    output cap_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
           busy, frame_seq
  );

  // DUT result producer / stream consumer side
  modport slave (
    output cap_valid, cap_bus, m_axis_tready,
    input  cap_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast,
           busy, frame_seq
  );
endinterface

// File: rtl/dut2vip_axis_tx.sv
// C2H transmitter: snapshots one wide DUT result vector and sends it as a
// framed AXI-Stream packet (one header beat, then WORDS_NUM data beats,
// least significant word first, tlast on the final beat).
module dut2vip_axis_tx #(
  parameter int C_DATA_WIDTH = 256,
  parameter int WORDS_NUM    = 16
) (
  input  logic                   m_axis_aclk,
  input  logic                   m_axis_areset,
  dut2vip_axis_tx_if.master      axis
);

  localparam int KEEP_W = C_DATA_WIDTH / 8;
  localparam int SNAP_W = C_DATA_WIDTH * WORDS_NUM;
  // Beat index width; padded word table keeps the mux index exact-width.
  localparam int IDX_W  = (WORDS_NUM > 1) ? $clog2(WORDS_NUM) : 1;
  localparam int SLOTS  = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORDS_NUM - 1);
  localparam logic [15:0]      MAGIC       = 16'hA5C3;
  localparam logic [15:0]      WORDS_FIELD = 16'(WORDS_NUM);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  logic clk;
  logic srst;
  assign clk  = m_axis_aclk;
  assign srst = m_axis_areset;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   beat_q, beat_d;
  logic [15:0]        frame_seq_q, frame_seq_d;
  logic [SNAP_W-1:0]  snap_q, snap_d;

  logic                    capture;
  logic                    beat_is_last;
  logic [C_DATA_WIDTH-1:0] hdr_word;
  logic [C_DATA_WIDTH-1:0] snap_word [SLOTS];

  // Slice the snapshot into per-beat words; unused slots read as zero
  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_word
      if (gi < WORDS_NUM) begin : g_live
        assign snap_word[gi] = snap_q[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
      end else begin : g_pad
        assign snap_word[gi] = '0;
      end
    end
  endgenerate

  assign capture      = (state_q == ST_IDLE) && axis.cap_valid;
  assign beat_is_last = (beat_q == LAST_IDX);

  // Header beat: magic, current sequence number, beat count; rest zero
  always_comb begin
    hdr_word        = '0;
    hdr_word[15:0]  = MAGIC;
    hdr_word[31:16] = frame_seq_q;
    hdr_word[47:32] = WORDS_FIELD;
  end

  // Next-state: capture in IDLE, advance on each stream handshake
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    frame_seq_d = frame_seq_q;
    snap_d      = snap_q;
    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          snap_d  = axis.cap_bus;
          beat_d  = '0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        if (axis.m_axis_tready) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (axis.m_axis_tready) begin
          if (beat_is_last) begin
            frame_seq_d = frame_seq_q + 16'd1;
            state_d     = ST_IDLE;
          end else begin
            beat_d = beat_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any frame in flight
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      frame_seq_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      frame_seq_q <= frame_seq_d;
    end
  end

  // Snapshot register; only loaded on capture, so no reset is needed
  always_ff @(posedge clk) begin
    if (!srst) begin
      snap_q <= snap_d;
    end
  end

  // Outputs decoded purely from registered state
  always_comb begin
    axis.cap_ready     = (state_q == ST_IDLE);
    axis.busy          = (state_q != ST_IDLE);
    axis.m_axis_tvalid = (state_q != ST_IDLE);
    axis.m_axis_tkeep  = (state_q != ST_IDLE) ? {KEEP_W{1'b1}} : '0;
    axis.m_axis_tlast  = (state_q == ST_DATA) && beat_is_last;
    axis.frame_seq     = frame_seq_q;
    case (state_q)
      ST_HDR:  axis.m_axis_tdata = hdr_word;
      ST_DATA: axis.m_axis_tdata = snap_word[beat_q];
      default: axis.m_axis_tdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dut2vip_axis_tx.sv
// Bench for dut2vip_axis_tx: a cycle vector table on a WORDS_NUM=1 instance,
// plus a queue-based frame model driving directed and random traffic on a
// 256x16 instance.
module tb_dut2vip_axis_tx;
  localparam int W  = 256;
  localparam int N  = 16;
  localparam int W1 = 64;
  localparam int N1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic srst_a;
  logic srst_b;

  dut2vip_axis_tx_if #(.C_DATA_WIDTH(W),  .WORDS_NUM(N))  bus_a ();
  dut2vip_axis_tx_if #(.C_DATA_WIDTH(W1), .WORDS_NUM(N1)) bus_b ();

  dut2vip_axis_tx #(.C_DATA_WIDTH(W), .WORDS_NUM(N)) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (srst_a),
    .axis          (bus_a.master)
  );

  dut2vip_axis_tx #(.C_DATA_WIDTH(W1), .WORDS_NUM(N1)) dut1 (
    .m_axis_aclk   (clk),
    .m_axis_areset (srst_b),
    .axis          (bus_b.master)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // ---------------- frame model for the 256x16 instance ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [15:0]  m_seq;
  logic         prev_stall;
  logic [W-1:0] prev_data;
  logic         prev_last;

  function automatic void push_frame(input logic [W*N-1:0] cb);
    beat_t b;
    b.data        = '0;
    b.data[15:0]  = 16'hA5C3;
    b.data[31:16] = m_seq;
    b.data[47:32] = 16'(N);
    b.last        = 1'b0;
    exp_q.push_back(b);
    for (int i = 0; i < N; i++) begin
      b.data = cb[i*W +: W];
      b.last = (i == N - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic logic [W*N-1:0] rand_bus();
    logic [W*N-1:0] r;
    for (int i = 0; i < W*N/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One cycle on instance A: drive, check against model, advance model
  task automatic tick_a(input logic cv, input logic tr, input logic [W*N-1:0] cb, input logic rst);
    logic             ev;
    logic [W/8-1:0]   ones;
    beat_t            b;
    ones = '1;
    bus_a.cap_valid     = cv;
    bus_a.m_axis_tready = tr;
    bus_a.cap_bus       = cb;
    srst_a              = rst;
    #2;
    ev = (exp_q.size() != 0);
    chk("tvalid",    bus_a.m_axis_tvalid, ev);
    chk("cap_ready", bus_a.cap_ready, !ev);
    chk("busy",      bus_a.busy, ev);
    chk("frame_seq", bus_a.frame_seq, m_seq);
    chk("tkeep",     bus_a.m_axis_tkeep, ev ? ones : '0);
    if (prev_stall) begin
      chk("stall_tdata", bus_a.m_axis_tdata, prev_data);
      chk("stall_tlast", bus_a.m_axis_tlast, prev_last);
    end
    if (ev) begin
      chk("tdata", bus_a.m_axis_tdata, exp_q[0].data);
      chk("tlast", bus_a.m_axis_tlast, exp_q[0].last);
    end else begin
      chk("tlast_idle", bus_a.m_axis_tlast, 1'b0);
    end
    prev_stall = ev && !tr && !rst;
    prev_data  = bus_a.m_axis_tdata;
    prev_last  = bus_a.m_axis_tlast;
    if (rst) begin
      exp_q.delete();
      m_seq = 16'd0;
    end else if (ev && tr) begin
      b = exp_q.pop_front();
      if (b.last) m_seq = m_seq + 16'd1;
    end else if (!ev && cv) begin
      push_frame(cb);
    end
    @(posedge clk);
    #1;
  endtask

  // Capture one frame and run it to completion (optionally with backpressure)
  task automatic send_frame(input logic [W*N-1:0] cb, input bit bp);
    tick_a(1'b1, 1'b1, cb, 1'b0);
    for (int k = 0; k < 4000 && exp_q.size() != 0; k++)
      tick_a(1'b0, bp ? 1'($urandom_range(0, 1)) : 1'b1, rand_bus(), 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_timeout remaining=%0d required=0", exp_q.size());
    end
  endtask

  // ---------------- vector table for the 64x1 instance ----------------
  typedef struct {
    logic        cv;
    logic        tr;
    logic        rst;
    logic [63:0] cb;
    logic        e_valid;
    logic        e_ready;
    logic        e_last;
    logic        e_dchk;
    logic [63:0] e_data;
    logic [15:0] e_seq;
  } vec_t;

  vec_t vecs[13];

  logic [W*N-1:0] single_bus;
  logic [W*N-1:0] iso_bus;

  initial begin
    // Inputs at a known value, reset both instances
    bus_a.cap_valid = 1'b0; bus_a.m_axis_tready = 1'b0; bus_a.cap_bus = '0;
    bus_b.cap_valid = 1'b0; bus_b.m_axis_tready = 1'b0; bus_b.cap_bus = '0;
    srst_a = 1'b1; srst_b = 1'b1;
    m_seq = 16'd0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    srst_a = 1'b0; srst_b = 1'b0;
    #1;
    chk("rst_tdata_a", bus_a.m_axis_tdata, '0);
    chk("rst_tvalid_a", bus_a.m_axis_tvalid, 1'b0);

    // WORDS_NUM=1 vectors: expected outputs in the cycle the inputs are applied
    //          cv    tr    rst   cb                     val   rdy   last  dchk  data                   seq
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 64'h0,                 1'b0, 1'b1, 1'b0, 1'b1, 64'h0,                 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 64'hDEADBEEF01234567,  1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b1, 64'h00000001_0000A5C3, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 64'hFFFF0000FFFF0000,  1'b1, 1'b0, 1'b0, 1'b1, 64'h00000001_0000A5C3, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b1, 1'b1, 64'hDEADBEEF01234567,  16'd0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b1, 1'b1, 64'hDEADBEEF01234567,  16'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 64'h1111,              1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 16'd1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b1, 64'h00000001_0001A5C3, 16'd1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 64'h0,                 1'b1, 1'b0, 1'b1, 1'b1, 64'h1111,              16'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 64'h0,                 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 16'd2};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 64'h5555,              1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 16'd2};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 64'h0,                 1'b1, 1'b0, 1'b0, 1'b1, 64'h00000001_0002A5C3, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 64'h0,                 1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 16'd0};

    for (int v = 0; v < 13; v++) begin
      bus_b.cap_valid     = vecs[v].cv;
      bus_b.m_axis_tready = vecs[v].tr;
      bus_b.cap_bus       = vecs[v].cb;
      srst_b              = vecs[v].rst;
      #2;
      chk($sformatf("w1_v%0d_tvalid", v), bus_b.m_axis_tvalid, vecs[v].e_valid);
      chk($sformatf("w1_v%0d_ready", v),  bus_b.cap_ready, vecs[v].e_ready);
      chk($sformatf("w1_v%0d_busy", v),   bus_b.busy, vecs[v].e_valid);
      chk($sformatf("w1_v%0d_tlast", v),  bus_b.m_axis_tlast, vecs[v].e_last);
      chk($sformatf("w1_v%0d_tkeep", v),  bus_b.m_axis_tkeep, vecs[v].e_valid ? 8'hFF : 8'h00);
      chk($sformatf("w1_v%0d_seq", v),    bus_b.frame_seq, vecs[v].e_seq);
      if (vecs[v].e_dchk)
        chk($sformatf("w1_v%0d_tdata", v), bus_b.m_axis_tdata, vecs[v].e_data);
      @(posedge clk);
      #1;
    end
    srst_b = 1'b0;

    // Single frame, tready held high
    for (int i = 0; i < N; i++) single_bus[i*W +: W] = {8{32'h1000_0000 + 32'(i)}};
    tick_a(1'b0, 1'b1, '0, 1'b0);
    send_frame(single_bus, 1'b0);
    tick_a(1'b0, 1'b1, '0, 1'b0);

    // Same content under 50% backpressure
    send_frame(single_bus, 1'b1);

    // Capture isolation: bus changes and cap_valid pulses while busy
    iso_bus = rand_bus();
    tick_a(1'b1, 1'b1, iso_bus, 1'b0);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++)
      tick_a(exp_q.size() > 1 ? 1'($urandom_range(0, 1)) : 1'b0, 1'b1, rand_bus(), 1'b0);
    tick_a(1'b0, 1'b1, '0, 1'b0);
    tick_a(1'b0, 1'b1, '0, 1'b0);

    // Back-to-back: cap_valid held high across two whole frames
    for (int k = 0; k < 2*(N+2); k++) tick_a(1'b1, 1'b1, rand_bus(), 1'b0);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick_a(1'b0, 1'b1, '0, 1'b0);

    // Sequence wrap: preload the counter while idle
    force dut.frame_seq_q = 16'hFFFE;
    #1;
    release dut.frame_seq_q;
    m_seq = 16'hFFFE;
    for (int f = 0; f < 3; f++) send_frame(rand_bus(), 1'b0);

    // Reset after data beat 5 handshakes (header + 6 data beats popped)
    tick_a(1'b1, 1'b1, rand_bus(), 1'b0);
    for (int k = 0; k < 50 && exp_q.size() > N + 1 - 7; k++) tick_a(1'b0, 1'b1, '0, 1'b0);
    tick_a(1'b0, 1'b1, '0, 1'b1);
    send_frame(single_bus, 1'b0);

    // Random traffic with backpressure and stray cap_valid
    for (int k = 0; k < 1500; k++)
      tick_a($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), rand_bus(), 1'b0);
    for (int k = 0; k < 400 && exp_q.size() != 0; k++)
      tick_a(1'b0, 1'($urandom_range(0, 1)), '0, 1'b0);
    tick_a(1'b0, 1'b1, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
